// File: rtl/rob_wb_arbiter.sv
// rob_wb_arbiter
// Merges the writeback streams of the reservation stations (RS) and the
// load/store buffer (LSB) onto the reorder buffer's single result-write port.
// Each producer feeds its own small registered FIFO, so a result that loses
// arbitration waits in its FIFO and is never dropped. The FIFO heads are
// granted round-robin.
//
// Ports
//   clk_in, rst_in          clock (rising edge); asynchronous active-low reset
//   rdy_in                  global enable; low freezes all state
//   predict_fail            flush every buffered result
//   rs_valid/tag/val/ready  RS result input handshake
//   lsb_valid/tag/val/ready LSB result input handshake
//   out_valid/tag/val/src   granted result to the ROB (src 0 = RS, 1 = LSB)
//   out_ready               ROB accepts the presented result
//   rs_count, lsb_count     FIFO occupancy
//
// Handshake: a transfer happens at a rising edge exactly when valid && ready
// are both high. ready never depends on valid, and while out_valid=1 and
// out_ready=0 the presented result holds unless predict_fail or rdy_in=0
// intervenes.
module rob_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int VAL_W = 32
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     predict_fail,
  input  logic                     rs_valid,
  input  logic [TAG_W-1:0]         rs_tag,
  input  logic [VAL_W-1:0]         rs_val,
  output logic                     rs_ready,
  input  logic                     lsb_valid,
  input  logic [TAG_W-1:0]         lsb_tag,
  input  logic [VAL_W-1:0]         lsb_val,
  output logic                     lsb_ready,
  output logic                     out_valid,
  output logic [TAG_W-1:0]         out_tag,
  output logic [VAL_W-1:0]         out_val,
  output logic                     out_src,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   rs_count,
  output logic [$clog2(DEPTH):0]   lsb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TAG_W + VAL_W;

  // Index 0 is the RS FIFO, index 1 the LSB FIFO.
  logic [EW-1:0] mem [2][DEPTH];
  logic [PW-1:0] head [2];
  logic [PW-1:0] tail [2];
  logic [CW-1:0] cnt  [2];
  logic          rr_pri;   // 0: RS wins a tie, 1: LSB wins a tie

  logic [EW-1:0] in_ent [2];
  logic [1:0]    in_valid;
  logic [1:0]    can_acc;
  logic [1:0]    nonempty;
  logic [1:0]    push;
  logic [1:0]    pop;
  logic          active;
  logic          sel_lsb;
  logic          grant;
  logic [EW-1:0] head_ent;

  assign in_ent[0] = {rs_tag, rs_val};
  assign in_ent[1] = {lsb_tag, lsb_val};
  assign in_valid  = {lsb_valid, rs_valid};

  assign active = rdy_in && !predict_fail;

  // Readiness looks only at the current count, so a full FIFO stays
  // not-ready even in a cycle where its head is being granted.
  always_comb begin
    can_acc  = '0;
    nonempty = '0;
    push     = '0;
    for (int s = 0; s < 2; s++) begin
      can_acc[s]  = active && (cnt[s] != CW'(DEPTH));
      nonempty[s] = (cnt[s] != '0);
      push[s]     = in_valid[s] && can_acc[s];
    end
  end

  // While in reset the producers see ready=1 so they are not stalled by
  // a block that is about to come up empty.
  assign rs_ready  = !rst_in || can_acc[0];
  assign lsb_ready = !rst_in || can_acc[1];

  assign sel_lsb   = nonempty[1] && (!nonempty[0] || rr_pri);
  assign out_valid = active && (nonempty[0] || nonempty[1]);
  assign head_ent  = sel_lsb ? mem[1][head[1]] : mem[0][head[0]];
  assign out_tag   = out_valid ? head_ent[EW-1:VAL_W] : '0;
  assign out_val   = out_valid ? head_ent[VAL_W-1:0]  : '0;
  assign out_src   = out_valid && sel_lsb;

  assign grant  = out_valid && out_ready;
  assign pop[0] = grant && !sel_lsb;
  assign pop[1] = grant && sel_lsb;

  assign rs_count  = cnt[0];
  assign lsb_count = cnt[1];

  // Storage is not reset; an entry is only visible once its count says so.
  always_ff @(posedge clk_in) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem[s][tail[s]] <= in_ent[s];
    end
  end

  // DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int s = 0; s < 2; s++) begin
        head[s] <= '0;
        tail[s] <= '0;
        cnt[s]  <= '0;
      end
      rr_pri <= 1'b0;
    end else if (rdy_in) begin
      if (predict_fail) begin
        for (int s = 0; s < 2; s++) begin
          head[s] <= '0;
          tail[s] <= '0;
          cnt[s]  <= '0;
        end
        rr_pri <= 1'b0;
      end else begin
        for (int s = 0; s < 2; s++) begin
          if (push[s]) tail[s] <= tail[s] + PW'(1);
          if (pop[s])  head[s] <= head[s] + PW'(1);
          if (push[s] && !pop[s])      cnt[s] <= cnt[s] + CW'(1);
          else if (!push[s] && pop[s]) cnt[s] <= cnt[s] - CW'(1);
        end
        // The source just served loses priority for the next tie.
        if (grant) rr_pri <= ~sel_lsb;
      end
    end
  end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Directed bench for rob_wb_arbiter (DEPTH=2, TAG_W=4, VAL_W=32).
// Stimulus pushes the expected {src,tag,val} of every result it expects the
// ROB to receive; a negedge monitor pops and compares on each grant.
module tb_rob_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int VAL_W = 32;
  localparam int W     = 1 + TAG_W + VAL_W;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             predict_fail;
  logic             rs_valid;
  logic [TAG_W-1:0] rs_tag;
  logic [VAL_W-1:0] rs_val;
  logic             rs_ready;
  logic             lsb_valid;
  logic [TAG_W-1:0] lsb_tag;
  logic [VAL_W-1:0] lsb_val;
  logic             lsb_ready;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [VAL_W-1:0] out_val;
  logic             out_src;
  logic             out_ready;
  logic [CW-1:0]    rs_count;
  logic [CW-1:0]    lsb_count;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  rob_wb_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W), .VAL_W(VAL_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .predict_fail(predict_fail),
    .rs_valid(rs_valid), .rs_tag(rs_tag), .rs_val(rs_val), .rs_ready(rs_ready),
    .lsb_valid(lsb_valid), .lsb_tag(lsb_tag), .lsb_val(lsb_val),
    .lsb_ready(lsb_ready),
    .out_valid(out_valid), .out_tag(out_tag), .out_val(out_val),
    .out_src(out_src), .out_ready(out_ready),
    .rs_count(rs_count), .lsb_count(lsb_count)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- helpers / driver tasks ----------------
  function automatic logic [W-1:0] ent(input logic src, input logic [TAG_W-1:0] tag,
                                       input logic [VAL_W-1:0] val);
    return {src, tag, val};
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_rs(input logic v, input logic [TAG_W-1:0] t, input logic [VAL_W-1:0] d);
    rs_valid = v;
    rs_tag   = t;
    rs_val   = d;
  endtask

  task automatic drive_lsb(input logic v, input logic [TAG_W-1:0] t, input logic [VAL_W-1:0] d);
    lsb_valid = v;
    lsb_tag   = t;
    lsb_val   = d;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_in) begin
    if (rst_in && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got src=%0d tag=%0h val=%0h want none",
                 out_src, out_tag, out_val);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({out_src, out_tag, out_val} !== e) begin
          errors++;
          $display("FAIL grant: got src=%0d tag=%0h val=%0h want src=%0d tag=%0h val=%0h",
                   out_src, out_tag, out_val, e[W-1], e[W-2:VAL_W], e[VAL_W-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_in       = 1'b0;
    rdy_in       = 1'b1;
    predict_fail = 1'b0;
    out_ready    = 1'b0;
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);

    // Reset state
    #2;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_rs_ready",  64'(rs_ready),  64'd1);
    chk("reset_lsb_ready", 64'(lsb_ready), 64'd1);
    chk("reset_rs_count",  64'(rs_count),  64'd0);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;

    // Single RS result, one-cycle latency
    drive_rs(1'b1, 4'd3, 32'h11);
    out_ready = 1'b1;
    exp_q.push_back(ent(1'b0, 4'd3, 32'h11));
    tick();
    drive_rs(1'b0, '0, '0);
    @(negedge clk_in);
    chk("t1_rs_count_after_push", 64'(rs_count), 64'd1);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk_in);
    chk("t1_rs_count_after_pop", 64'(rs_count), 64'd0);
    chk("t1_out_valid_empty", 64'(out_valid), 64'd0);

    // Empty flush returns tie priority to RS
    tick();
    predict_fail = 1'b1;
    tick();
    predict_fail = 1'b0;

    // Round-robin between two loaded FIFOs
    out_ready = 1'b0;
    drive_rs(1'b1, 4'd1, 32'h101);
    drive_lsb(1'b1, 4'd5, 32'h505);
    exp_q.push_back(ent(1'b0, 4'd1, 32'h101));
    exp_q.push_back(ent(1'b1, 4'd5, 32'h505));
    exp_q.push_back(ent(1'b0, 4'd2, 32'h202));
    exp_q.push_back(ent(1'b1, 4'd6, 32'h606));
    tick();
    drive_rs(1'b1, 4'd2, 32'h202);
    drive_lsb(1'b1, 4'd6, 32'h606);
    tick();
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);
    out_ready = 1'b1;
    @(negedge clk_in);
    chk("t2_rs_count_loaded",  64'(rs_count),  64'd2);
    chk("t2_lsb_count_loaded", 64'(lsb_count), 64'd2);
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk_in);
    chk("t2_rs_count_drained",  64'(rs_count),  64'd0);
    chk("t2_lsb_count_drained", 64'(lsb_count), 64'd0);

    // RS backpressure at DEPTH=2, no pass-through, push+pop same edge
    tick();
    out_ready = 1'b0;
    exp_q.push_back(ent(1'b0, 4'd7, 32'h77));
    exp_q.push_back(ent(1'b0, 4'd8, 32'h88));
    exp_q.push_back(ent(1'b0, 4'd9, 32'h99));
    drive_rs(1'b1, 4'd7, 32'h77);
    tick();
    drive_rs(1'b1, 4'd8, 32'h88);
    tick();
    drive_rs(1'b1, 4'd9, 32'h99);
    @(negedge clk_in);
    chk("t3_rs_ready_full", 64'(rs_ready), 64'd0);
    chk("t3_rs_count_full", 64'(rs_count), 64'd2);
    chk("t3_out_tag_head",  64'(out_tag),  64'd7);
    tick();
    @(negedge clk_in);
    chk("t3_rs_count_held",  64'(rs_count), 64'd2);
    chk("t3_out_tag_stable", 64'(out_tag),  64'd7);
    tick();
    out_ready = 1'b1;
    @(negedge clk_in);
    chk("t3_no_passthrough", 64'(rs_ready), 64'd0);
    tick();
    @(negedge clk_in);
    chk("t3_ready_after_pop", 64'(rs_ready), 64'd1);
    chk("t3_count_after_pop", 64'(rs_count), 64'd1);
    tick();
    drive_rs(1'b0, '0, '0);
    @(negedge clk_in);
    chk("t3_count_push_pop", 64'(rs_count), 64'd1);
    tick();
    @(negedge clk_in);
    chk("t3_count_drained", 64'(rs_count), 64'd0);

    // Flush with three entries pending (tie priority is LSB beforehand)
    tick();
    out_ready = 1'b0;
    drive_rs(1'b1, 4'hA, 32'hA0);
    drive_lsb(1'b1, 4'hC, 32'hC0);
    tick();
    drive_rs(1'b1, 4'hB, 32'hB0);
    drive_lsb(1'b0, '0, '0);
    tick();
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b1, 4'hD, 32'hD0);
    predict_fail = 1'b1;
    out_ready    = 1'b1;
    @(negedge clk_in);
    chk("t4_flush_out_valid", 64'(out_valid), 64'd0);
    chk("t4_flush_lsb_ready", 64'(lsb_ready), 64'd0);
    tick();
    predict_fail = 1'b0;
    drive_lsb(1'b0, '0, '0);
    out_ready = 1'b0;
    @(negedge clk_in);
    chk("t4_rs_count_flushed",  64'(rs_count),  64'd0);
    chk("t4_lsb_count_flushed", 64'(lsb_count), 64'd0);
    chk("t4_out_valid_flushed", 64'(out_valid), 64'd0);
    tick();
    drive_rs(1'b1, 4'hE, 32'hE0);
    drive_lsb(1'b1, 4'hF, 32'hF0);
    exp_q.push_back(ent(1'b0, 4'hE, 32'hE0));
    exp_q.push_back(ent(1'b1, 4'hF, 32'hF0));
    tick();
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);
    out_ready = 1'b1;
    tick();
    tick();
    @(negedge clk_in);
    chk("t4_drained", 64'({rs_count, lsb_count}), 64'd0);

    // Pause with entries pending
    tick();
    out_ready = 1'b0;
    exp_q.push_back(ent(1'b0, 4'd4, 32'h44));
    exp_q.push_back(ent(1'b0, 4'd5, 32'h55));
    drive_rs(1'b1, 4'd4, 32'h44);
    tick();
    drive_rs(1'b1, 4'd5, 32'h55);
    tick();
    rdy_in    = 1'b0;
    drive_rs(1'b1, 4'd9, 32'h9999);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      chk("t5_pause_out_valid", 64'(out_valid), 64'd0);
      chk("t5_pause_rs_ready",  64'(rs_ready),  64'd0);
      chk("t5_pause_rs_count",  64'(rs_count),  64'd2);
      tick();
    end
    rdy_in = 1'b1;
    drive_rs(1'b0, '0, '0);
    tick();
    tick();
    @(negedge clk_in);
    chk("t5_drained", 64'(rs_count), 64'd0);

    // Asynchronous reset while full
    tick();
    out_ready = 1'b0;
    drive_rs(1'b1, 4'd1, 32'h1);
    drive_lsb(1'b1, 4'd3, 32'h3);
    tick();
    drive_rs(1'b1, 4'd2, 32'h2);
    drive_lsb(1'b1, 4'd4, 32'h4);
    tick();
    drive_rs(1'b0, '0, '0);
    drive_lsb(1'b0, '0, '0);
    @(negedge clk_in);
    chk("t6_full_before_reset", 64'({rs_count, lsb_count}), 64'({CW'(2), CW'(2)}));
    #2;
    rst_in = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_out_tag",   64'(out_tag),   64'd0);
    chk("t6_rst_out_val",   64'(out_val),   64'd0);
    chk("t6_rst_rs_ready",  64'(rs_ready),  64'd1);
    chk("t6_rst_lsb_ready", 64'(lsb_ready), 64'd1);
    chk("t6_rst_counts",    64'({rs_count, lsb_count}), 64'd0);
    #1;
    rst_in    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      chk("t6_no_stale_out", 64'(out_valid), 64'd0);
      tick();
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rob_wb_arbiter.md
Name: rob_wb_arbiter

Overview:
- Shares the reorder buffer's single result-write port between the two execution-side producers: reservation stations (RS) and load/store buffer (LSB).
- Each producer gets a small registered FIFO so a lost arbitration never drops a result.
- Heads are granted round-robin onto one valid/ready port into the ROB.
- Sits between RS/LSB writeback outputs and the ROB submit inputs; flushed by the branch predictor's predict_fail.

Parameters:
- DEPTH, 2, entries per producer FIFO; legal values 2, 4, 8.
- TAG_W, 4, ROB tag width.
- VAL_W, 32, result value width.

Ports:
- clk_in  input  1  clock, all state on rising edge
- rst_in  input  1  asynchronous, active-low reset
- rdy_in  input  1  global enable; low = pause
- predict_fail  input  1  flush all buffered results
- rs_valid  input  1  RS result offered
- rs_tag  input  TAG_W  RS result ROB tag
- rs_val  input  VAL_W  RS result value
- rs_ready  output  1  RS FIFO can accept
- lsb_valid  input  1  LSB result offered
- lsb_tag  input  TAG_W  LSB result ROB tag
- lsb_val  input  VAL_W  LSB result value
- lsb_ready  output  1  LSB FIFO can accept
- out_valid  output  1  result presented to ROB
- out_tag  output  TAG_W  granted tag
- out_val  output  VAL_W  granted value
- out_src  output  1  0 = RS, 1 = LSB
- out_ready  input  1  ROB accepts this cycle
- rs_count  output  $clog2(DEPTH)+1  RS FIFO occupancy
- lsb_count  output  $clog2(DEPTH)+1  LSB FIFO occupancy

Behaviour:
- Reset (rst_in=0, async): both FIFOs empty, counts 0, head/tail pointers 0, rr_pri=0 (RS first).
  - Outputs during reset: out_valid=0, out_tag=0, out_val=0, out_src=0, rs_ready=1, lsb_ready=1.
  - Reset asserted mid-operation discards all entries immediately.
- Readiness:
  - rs_ready = rdy_in && !predict_fail && rs_count<DEPTH; lsb_ready likewise.
  - No pass-through: a full FIFO stays not-ready even in a cycle where it is popped.
- Push: valid && ready at an edge writes {tag,val} at the tail; tail wraps DEPTH-1 -> 0; count+1.
- Latency: a result pushed at edge N can appear on out_* from cycle N+1. There is no combinational in->out path.
- Output selection (combinational from FIFO heads):
  - out_valid = rdy_in && !predict_fail && (rs_count!=0 || lsb_count!=0).
  - Only one source non-empty: select it.
  - Both non-empty: select RS if rr_pri=0, else LSB.
  - out_tag/out_val/out_src come from the selected head; all zero when out_valid=0.
- Grant: out_valid && out_ready at an edge pops the selected head (head wraps, count-1).
  - rr_pri is then set to the opposite of out_src.
  - rr_pri is unchanged when there is no grant.
- Push and pop of the same FIFO in one edge: count unchanged, both pointers advance.
- Stability: out_* must hold while out_valid=1 && out_ready=0, unless predict_fail or rdy_in=0 intervenes.
- Flush (predict_fail=1 with rdy_in=1):
  - Next edge: both FIFOs empty, pointers 0, rr_pri=0.
  - Same-cycle inputs are discarded, no grant occurs, out_valid=0.
- Pause (rdy_in=0):
  - No push, pop, flush or rr_pri change.
  - rs_ready=lsb_ready=out_valid=0.
  - Contents and counts are frozen.
- Ordering: per-source FIFO order is preserved. No ordering is guaranteed between sources.

Test Plan:
- Reset, then RS pushes tag 3 val 0x11 at edge 1 -> out_valid=1, out_tag=3, out_val=0x11, out_src=0 in cycle 2; with out_ready=1, rs_count returns to 0 after edge 2.
- Both FIFOs loaded (RS tags 1,2; LSB tags 5,6), out_ready=1 continuous -> grant order 1,5,2,6, out_src 0,1,0,1.
- out_ready=0, RS pushes 3 results with DEPTH=2 -> rs_ready drops after 2 accepts, rs_count=2, third value held by producer; out_tag stable.
- FIFOs holding 3 entries total, predict_fail=1 for one cycle -> next cycle counts 0, out_valid=0, rr_pri=0; same-cycle pushes lost.
- rdy_in=0 for 4 cycles with entries pending and out_ready=1 -> no grant, counts unchanged; resumes with same head after rdy_in=1.
- rst_in pulled low asynchronously between edges while full -> outputs zero immediately, ready=1; no stale tag after release.
